multiplier_controller_param: RTL and testbench
==============================================

Name: multiplier_controller_param

Overview:
Parametrised sequencing controller for the digit-serial N×N multiplier, where N = NUM_DIGITS × digit width. It walks every operand digit pair (i, j) through the shared digit multiplier, one pair per enabled cycle. For each pair it drives the operand mux selects, the partial-product shift amount and the accumulator clear/enable. It generates the pair index internally, so no external count is needed, and it adds stall, abort and busy over the fixed 2-digit controller.

Parameters:
NUM_DIGITS, 2, digits per operand (≥2); partial products P = NUM_DIGITS².
SEL_W (localparam), max(1, clog2(NUM_DIGITS)), width of the digit selects.
SHF_W (localparam), clog2(2·NUM_DIGITS−1), width of the shift select.

Ports:
clk  in  1  rising-edge clock
reset_a  in  1  asynchronous reset, active-high
start  in  1  request a new multiply; sampled only in IDLE/DONE
stall  in  1  hold the current pair; no accumulate this cycle
abort  in  1  cancel the operation in progress
a_sel  out  SEL_W  digit index i of operand A
b_sel  out  SEL_W  digit index j of operand B
shift_sel  out  SHF_W  partial-product shift in digits, = i + j
state_out  out  3  current state encoding
clk_ena  out  1  accumulator/product register enable
sclr_n  out  1  synchronous accumulator clear, active-low
busy  out  1  high in CLEAR or CALC
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs decode combinationally from registered state and counters (Moore). There are no input-to-output paths.
- Reset (asynchronous, any time, including mid-operation) forces: state IDLE, i = j = 0, a_sel = b_sel = shift_sel = 0, state_out = 0, clk_ena = 0, sclr_n = 1, busy = 0, done = 0.
- State encodings: IDLE = 3'd0, CLEAR = 3'd1, CALC = 3'd2, DONE = 3'd3. Codes 4–7 are illegal and recover to IDLE on the next edge.
- IDLE: clk_ena = 0, sclr_n = 1.
  - start = 1 and abort = 0 → CLEAR.
  - abort wins over start.
- CLEAR: sclr_n = 0, clk_ena = 1, i = j = 0. Always → CALC next edge, unless abort. Stall is ignored in CLEAR.
- CALC: a_sel = i, b_sel = j, shift_sel = i + j.
  - clk_ena = ~stall.
  - Ordering: j is the inner loop. (0,0), (0,1) … (0,N−1), (1,0) … (N−1,N−1), where N = NUM_DIGITS.
  - Each edge with stall = 0 advances the pair; j wraps to 0 and carries into i.
  - At the last pair (N−1,N−1) with stall = 0 → DONE; the counters wrap to 0.
  - stall = 1 holds state and indices.
- DONE: done = 1, clk_ena = 0, sclr_n = 1, for exactly one cycle.
  - start = 1 → CLEAR (back-to-back operation, no IDLE gap).
  - Otherwise → IDLE.
- abort = 1 in CLEAR or CALC → IDLE next edge, counters zeroed, no done pulse. abort has priority over stall. abort in IDLE/DONE has no effect beyond suppressing start.
- start while busy is ignored and does not restart the operation.
- Latency with no stalls: start sampled at edge 0; CALC occupies edges 1..P; done is high in the cycle after edge P+1. Each stall cycle adds one cycle.
- busy = (state == CLEAR) | (state == CALC).

Decomposition:
- Package mult_ctrl_pkg: state encodings (IDLE/CLEAR/CALC/DONE as 3-bit constants) and the SEL_W/SHF_W width functions.
- Sub-module digit_pair_counter: parametrised nested i/j counter.
  - Inputs: clr, inc.
  - Outputs: i, j, last (high at pair (N−1,N−1)).
  - Instantiated once; the FSM owns the control and the counter owns the indexing.

Test Plan:
- Reset: assert reset_a mid-CALC (NUM_DIGITS=2, pair (1,0)) → all outputs return to reset values immediately without a clock edge; state_out = 0.
- Basic run, NUM_DIGITS=2: single start pulse → CLEAR 1 cycle (sclr_n = 0), then 4 CALC cycles with (a_sel, b_sel, shift_sel) = (0,0,0), (0,1,1), (1,0,1), (1,1,2), clk_ena = 1. done = 1 for one cycle at edge 5; then IDLE.
- NUM_DIGITS=3: 9 CALC cycles; shift_sel sequence 0,1,2,1,2,3,2,3,4; done after edge 10.
- Stall: NUM_DIGITS=2, stall = 1 for 2 cycles at pair (0,1) → indices held and clk_ena = 0 during the stall; done delayed 2 cycles, at edge 7.
- Abort: abort at pair (1,0) → IDLE next edge, done never asserts, busy drops. A subsequent start runs a full clean sequence from (0,0).
- Back-to-back and ignored start: start held high throughout → it is ignored while busy; start in DONE → CLEAR immediately, with a done pulse every P+2 cycles.

Source files
------------

// File: rtl/multiplier_controller_param_pkg.sv
// Shared state encodings and width helpers for the digit-serial multiplier controller.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        CALC  = 3'd2,
        DONE  = 3'd3
    } state_t;

    // Digit select width: max(1, clog2(num_digits)).
    function automatic int sel_width(input int num_digits);
        return ($clog2(num_digits) < 1) ? 1 : $clog2(num_digits);
    endfunction

    // Shift select must hold i + j up to 2*(num_digits-1).
    function automatic int shf_width(input int num_digits);
        return $clog2(2 * num_digits - 1);
    endfunction

endpackage

// File: rtl/multiplier_controller_param_if.sv
// Control/status bundle between the multiplier datapath owner and its sequencing controller.
interface multiplier_controller_param_if
    import mult_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 2
);
    localparam int SEL_W = sel_width(NUM_DIGITS);
    localparam int SHF_W = shf_width(NUM_DIGITS);

    logic             start;
    logic             stall;
    logic             abort;
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;
    logic [SHF_W-1:0] shift_sel;
    logic [2:0]       state_out;
    logic             clk_ena;
    logic             sclr_n;
    logic             busy;
    logic             done;

    modport master (
        output start, stall, abort,
        input  a_sel, b_sel, shift_sel, state_out, clk_ena, sclr_n, busy, done
    );

    modport slave (
        input  start, stall, abort,
        output a_sel, b_sel, shift_sel, state_out, clk_ena, sclr_n, busy, done
    );

endinterface

// File: rtl/multiplier_controller_param_digit_pair_counter.sv
// Nested digit-pair counter: j is the inner index, wrapping into i; both wrap after (N-1, N-1).
module digit_pair_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int SEL_W      = 1
) (
    input  logic             clk,
    input  logic             reset_a,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] i,
    output logic [SEL_W-1:0] j,
    output logic             last
);
    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(NUM_DIGITS - 1);

    logic j_last;
    logic i_last;

    assign j_last = (j == MAX_IDX);
    assign i_last = (i == MAX_IDX);
    assign last   = i_last && j_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            i <= '0;
            j <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
        end else if (inc) begin
            if (j_last) begin
                j <= '0;
                // Explicit wrap keeps non-power-of-two digit counts in range.
                i <= i_last ? '0 : i + SEL_W'(1);
            end else begin
                j <= j + SEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/multiplier_controller_param.sv
// Sequencing controller walking every operand digit pair through the shared digit multiplier.
module multiplier_controller_param
    import mult_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input logic                         clk,
    input logic                         reset_a,
    multiplier_controller_param_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_DIGITS);
    localparam int SHF_W = shf_width(NUM_DIGITS);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] i_idx;
    logic [SEL_W-1:0] j_idx;
    logic             last_pair;
    logic             cnt_clr;
    logic             cnt_inc;

    // Indices only move in CALC; any other state (or an abort) parks them at (0,0).
    assign cnt_clr = (state != CALC) || bus.abort;
    assign cnt_inc = (state == CALC) && !bus.stall;

    digit_pair_counter #(
        .NUM_DIGITS(NUM_DIGITS),
        .SEL_W     (SEL_W)
    ) u_pair_cnt (
        .clk    (clk),
        .reset_a(reset_a),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .i      (i_idx),
        .j      (j_idx),
        .last   (last_pair)
    );

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start && !bus.abort) state_next = CLEAR;
            CLEAR: state_next = bus.abort ? IDLE : CALC;
            CALC: begin
                if (bus.abort)                   state_next = IDLE;
                else if (!bus.stall && last_pair) state_next = DONE;
            end
            DONE:  state_next = (bus.start && !bus.abort) ? CLEAR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.a_sel     = '0;
        bus.b_sel     = '0;
        bus.shift_sel = '0;
        bus.state_out = state;
        bus.clk_ena   = 1'b0;
        bus.sclr_n    = 1'b1;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            CLEAR: begin
                bus.sclr_n  = 1'b0;
                bus.clk_ena = 1'b1;
                bus.busy    = 1'b1;
            end
            CALC: begin
                bus.a_sel     = i_idx;
                bus.b_sel     = j_idx;
                bus.shift_sel = SHF_W'(i_idx) + SHF_W'(j_idx);
                // A stalled pair must not be accumulated.
                bus.clk_ena   = !bus.stall;
                bus.busy      = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multiplier_controller_param.sv
// Bench for the digit-pair sequencing controller: vector table (N=2), corner sequences, random run (N=3).
module tb_multiplier_controller_param;

    logic clk = 1'b0;
    logic reset_a;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    multiplier_controller_param_if #(.NUM_DIGITS(2)) bus2 ();
    multiplier_controller_param_if #(.NUM_DIGITS(3)) bus3 ();

    multiplier_controller_param #(.NUM_DIGITS(2)) dut2 (
        .clk(clk), .reset_a(reset_a), .bus(bus2)
    );
    multiplier_controller_param #(.NUM_DIGITS(3)) dut3 (
        .clk(clk), .reset_a(reset_a), .bus(bus3)
    );

    typedef struct {
        bit start;
        bit stall;
        bit abort;
        int st;
        int a;
        int b;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One nibble per field: state, a_sel, b_sel, shift_sel, clk_ena, sclr_n, busy, done.
    function automatic logic [31:0] pk(input int st, a, b, sh, ena, sclr, bsy, dn);
        return {4'(st), 4'(a), 4'(b), 4'(sh), 4'(ena), 4'(sclr), 4'(bsy), 4'(dn)};
    endfunction

    // Expected outputs from the behavioural rules for a given state, pair and current stall.
    function automatic logic [31:0] expect_out(input int st, input int a, input int b, input bit stall);
        int ena;
        ena = (st == 1) ? 1 : (st == 2) ? int'(!stall) : 0;
        if (st != 2) begin
            a = 0;
            b = 0;
        end
        return pk(st, a, b, a + b, ena, int'(st != 1), int'(st == 1 || st == 2), int'(st == 3));
    endfunction

    function automatic logic [31:0] act2();
        return pk(int'(bus2.state_out), int'(bus2.a_sel), int'(bus2.b_sel), int'(bus2.shift_sel),
                  int'(bus2.clk_ena), int'(bus2.sclr_n), int'(bus2.busy), int'(bus2.done));
    endfunction

    function automatic logic [31:0] act3();
        return pk(int'(bus3.state_out), int'(bus3.a_sel), int'(bus3.b_sel), int'(bus3.shift_sel),
                  int'(bus3.clk_ena), int'(bus3.sclr_n), int'(bus3.busy), int'(bus3.done));
    endfunction

    task automatic add(input bit s, input bit sl, input bit ab, input int st, input int a = 0, input int b = 0);
        tbl.push_back('{s, sl, ab, st, a, b});
    endtask

    task automatic calc4(input bit s);
        add(s, 0, 0, 2, 0, 0);
        add(s, 0, 0, 2, 0, 1);
        add(s, 0, 0, 2, 1, 0);
        add(s, 0, 0, 2, 1, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference for N=3: k is the flat pair index (-1 while clearing); i = k/N, j = k%N.
    localparam int N3 = 3;
    localparam int P3 = N3 * N3;
    int m_k    = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    function automatic logic [31:0] model_out(input bit stall);
        int st;
        st = m_done ? 3 : !m_busy ? 0 : (m_k < 0) ? 1 : 2;
        return expect_out(st, (st == 2) ? m_k / N3 : 0, (st == 2) ? m_k % N3 : 0, stall);
    endfunction

    task automatic model_edge(input bit s, input bit sl, input bit ab);
        if (m_busy) begin
            if (ab) begin
                m_busy = 1'b0;
            end else if (m_k < 0) begin
                m_k = 0;
            end else if (!sl) begin
                if (m_k == P3 - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_k++;
                end
            end
        end else begin
            m_done = 1'b0;
            if (s && !ab) begin
                m_busy = 1'b1;
                m_k    = -1;
            end
        end
    endtask

    initial begin
        int shifts [9];
        logic [31:0] idle_rst;
        shifts   = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        idle_rst = pk(0, 0, 0, 0, 0, 1, 0, 0);

        reset_a    = 1'b1;
        bus2.start = 1'b0; bus2.stall = 1'b0; bus2.abort = 1'b0;
        bus3.start = 1'b0; bus3.stall = 1'b0; bus3.abort = 1'b0;
        #2;
        check("reset_n2", act2(), idle_rst);
        check("reset_n3", act3(), idle_rst);
        #20 reset_a = 1'b0;

        // Basic run
        add(1, 0, 0, 0); add(0, 0, 0, 1); calc4(0); add(0, 0, 0, 3); add(0, 0, 0, 0);
        // abort beats start in IDLE
        add(1, 0, 1, 0); add(0, 0, 0, 0);
        // two stall cycles at (0,1)
        add(1, 0, 0, 0); add(0, 0, 0, 1); add(0, 0, 0, 2, 0, 0);
        add(0, 1, 0, 2, 0, 1); add(0, 1, 0, 2, 0, 1); add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 2, 1, 0); add(0, 0, 0, 2, 1, 1); add(0, 0, 0, 3); add(0, 0, 0, 0);
        // stall ignored in CLEAR; abort with stall at (1,0); then a clean rerun
        add(1, 0, 0, 0); add(0, 1, 0, 1); add(0, 0, 0, 2, 0, 0); add(0, 0, 0, 2, 0, 1);
        add(0, 1, 1, 2, 1, 0); add(0, 0, 0, 0);
        add(1, 0, 0, 0); add(0, 0, 0, 1); calc4(0); add(0, 0, 0, 3); add(0, 0, 0, 0);
        // start held high: ignored while busy, taken in DONE
        add(1, 0, 0, 0); add(1, 0, 0, 1); calc4(1); add(1, 0, 0, 3);
        add(1, 0, 0, 1); calc4(1); add(0, 0, 0, 3); add(0, 0, 0, 0);
        // abort in CLEAR, and abort in DONE suppressing start
        add(1, 0, 0, 0); add(0, 0, 1, 1); add(0, 0, 0, 0);
        add(1, 0, 0, 0); add(0, 0, 0, 1); calc4(0); add(1, 0, 1, 3); add(0, 0, 0, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            @(posedge clk);
            #1;
            bus2.start = tbl[n].start;
            bus2.stall = tbl[n].stall;
            bus2.abort = tbl[n].abort;
            #1;
            check($sformatf("vec%0d", n), act2(),
                  expect_out(tbl[n].st, tbl[n].a, tbl[n].b, tbl[n].stall));
        end
        step();
        bus2.start = 1'b0; bus2.stall = 1'b0; bus2.abort = 1'b0;

        // Asynchronous reset mid-CALC at pair (1,0)
        step(); bus2.start = 1'b1;
        step(); bus2.start = 1'b0;
        step(); step(); step();
        check("pre_reset_pair10", act2(), expect_out(2, 1, 0, 1'b0));
        #2 reset_a = 1'b1;
        #1 check("async_reset", act2(), idle_rst);
        #4 reset_a = 1'b0;
        step();
        check("after_reset_idle", act2(), idle_rst);

        // N=3 sequence: 9 CALC cycles, done after edge 10
        bus3.start = 1'b1;
        step(); bus3.start = 1'b0;
        #1 check("n3_clear", act3(), expect_out(1, 0, 0, 1'b0));
        for (int k = 0; k < P3; k++) begin
            step();
            check($sformatf("n3_shift%0d", k), 32'(bus3.shift_sel), 32'(shifts[k]));
        end
        step(); check("n3_done", act3(), expect_out(3, 0, 0, 1'b0));
        step(); check("n3_idle", act3(), idle_rst);

        // Random stimulus on N=3 against the flat-index reference
        for (int c = 0; c < 400; c++) begin
            bit s, sl, ab;
            s  = ($urandom_range(0, 99) < 35);
            sl = ($urandom_range(0, 99) < 25);
            ab = ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #1;
            bus3.start = s;
            bus3.stall = sl;
            bus3.abort = ab;
            #1;
            check($sformatf("rand%0d", c), act3(), model_out(sl));
            model_edge(s, sl, ab);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
